// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : Two-requester arbiter in front of a shared bitwise logic unit
//            (AND/OR/XOR/NAND), round-robin on contention, one op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] in1_0,
  input  logic [WIDTH-1:0] in2_0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1_1,
  input  logic [WIDTH-1:0] in2_1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             owner,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ptr;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [1:0]       r_op;
  logic             w_any_req;
  logic             w_winner;
  logic [WIDTH-1:0] w_result;

  // On contention the pointer decides; otherwise the lone requester wins.
  always_comb begin
    w_any_req = req0 | req1;
    w_winner  = (req0 & req1) ? r_ptr : req1;
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_in1 & r_in2;
      2'b01:   w_result = r_in1 | r_in2;
      2'b10:   w_result = r_in1 ^ r_in2;
      default: w_result = ~(r_in1 & r_in2);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_next = EXEC;
      EXEC:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_op  <= '0;
      r_ptr <= 1'b0;
      owner <= 1'b0;
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_in1 <= w_winner ? in1_1 : in1_0;
            r_in2 <= w_winner ? in2_1 : in2_0;
            r_op  <= w_winner ? op1   : op0;
            owner <= w_winner;
          end
        end
        EXEC: begin
          out   <= w_result;
          valid <= 1'b1;
        end
        DONE: r_ptr <= ~owner;
        default: ;
      endcase
    end
  end

  // Grants are decoded from state so they vanish together with a reset.
  assign gnt0 = (r_state == EXEC) & ~owner;
  assign gnt1 = (r_state == EXEC) &  owner;
  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Purpose  : Scoreboard bench for logic_unit_arbiter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] in1_0 = '0, in2_0 = '0, in1_1 = '0, in2_1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        gnt0, gnt1, valid, owner, busy;
  logic [31:0] out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic [32:0] exp_q[$];   // {owner, out}
  logic        gnt_q[$];   // expected granted requester, in order

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .in1_0(in1_0), .in2_0(in2_0), .op0(op0),
    .req1(req1), .in1_1(in1_1), .in2_1(in2_1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .valid(valid), .out(out),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops plus protocol invariants, sampled on falling edge.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", {owner, out}, 33'h0);
      else begin
        e = exp_q.pop_front();
        check("result", {owner, out}, e);
      end
    end
    if (gnt0 | gnt1) begin
      if (gnt_q.size() == 0) check("unexpected_gnt", {31'h0, gnt1, gnt0}, 33'h0);
      else check("gnt_order", {31'h0, gnt1, gnt0},
                 gnt_q[0] ? 33'h2 : 33'h1);
      if (gnt_q.size() != 0) void'(gnt_q.pop_front());
    end
    check("gnt_exclusive", {32'h0, gnt0 & gnt1}, 33'h0);
    check("valid_single", {32'h0, valid & prev_valid}, 33'h0);
    check("busy_outside_idle", {32'h0, (gnt0 | gnt1 | valid) & ~busy}, 33'h0);
    prev_valid = valid;
  end

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) return;
    end
    check({name, "_gnt_timeout"}, 33'h0, 33'h1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) return;
    end
    check({name, "_valid_timeout"}, 33'h0, 33'h1);
  endtask

  task automatic run_op(input string name, input bit who, input logic [31:0] a, b,
                        input logic [1:0] op, input logic [31:0] exp, input bit corrupt);
    @(posedge clk); #1;
    exp_q.push_back({who, exp});
    gnt_q.push_back(who);
    if (who) begin in1_1 = a; in2_1 = b; op1 = op; req1 = 1'b1; end
    else     begin in1_0 = a; in2_0 = b; op0 = op; req0 = 1'b1; end
    wait_gnt(name);
    req0 = 1'b0; req1 = 1'b0;
    if (corrupt) begin in1_0 = 32'hFFFF_FFFF; in2_0 = 32'hFFFF_FFFF; op0 = 2'b01; end
    wait_valid(name);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int last;
    do_reset();
    @(negedge clk);
    check("reset_out",   {owner, out}, 33'h0);
    check("reset_flags", {28'h0, valid, gnt0, gnt1, busy, 1'b0}, 33'h0);

    run_op("r0_and", 1'b0, 32'h0000_A5A5, 32'h0000_5A5A, 2'b00, 32'h0000_0000, 1'b0);
    run_op("r1_and", 1'b1, 32'h0000_5A5A, 32'h0000_5A5A, 2'b00, 32'h0000_5A5A, 1'b0);
    run_op("r1_or",  1'b1, 32'h0000_5A5A, 32'h0000_5A5A, 2'b01, 32'h0000_5A5A, 1'b0);
    run_op("r1_xor", 1'b1, 32'h0000_5A5A, 32'h0000_5A5A, 2'b10, 32'h0000_0000, 1'b0);
    run_op("r1_nand",1'b1, 32'h0000_5A5A, 32'h0000_5A5A, 2'b11, 32'hFFFF_A5A5, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_after_valid", {owner, out}, {1'b1, 32'hFFFF_A5A5});

    // Contention from reset: strict alternation starting with requester 0.
    do_reset();
    @(posedge clk); #1;
    in1_0 = 32'hF0F0_F0F0; in2_0 = 32'hFF00_FF00; op0 = 2'b10;
    in1_1 = 32'h1234_5678; in2_1 = 32'h0F0F_0F0F; op1 = 2'b01;
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(k[0]);
      exp_q.push_back(k[0] ? {1'b1, 32'h1F3F_5F7F} : {1'b0, 32'h0FF0_0FF0});
    end
    req0 = 1'b1; req1 = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("contend");
      if (k > 0) check("valid_spacing", 33'(cyc - last), 33'd3);
      last = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Operands changed while granted must not leak into the result.
    run_op("latched", 1'b0, 32'h0000_FFFF, 32'h00FF_00FF, 2'b00, 32'h0000_00FF, 1'b1);

    // Abort in EXEC: requester 1 granted, then reset.
    @(posedge clk); #1;
    gnt_q.push_back(1'b1);
    in1_1 = 32'hDEAD_BEEF; in2_1 = 32'hFFFF_FFFF; op1 = 2'b00; req1 = 1'b1;
    wait_gnt("abort");
    #2 rst_n = 1'b0; req1 = 1'b0;
    #1;
    check("abort_out",   {owner, out}, 33'h0);
    check("abort_flags", {29'h0, valid, gnt0, gnt1, busy}, 33'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_op("post_reset", 1'b0, 32'hA5A5_A5A5, 32'h0000_FFFF, 2'b11, 32'hFFFF_5A5A, 1'b0);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 33'(exp_q.size()), 33'h0);
    check("gnt_q_drained", 33'(gnt_q.size()), 33'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ0  input  1  requester 0 wants an operation; held until GNT0 seen.
REQ-005 IN1_0, IN2_0  input  WIDTH each  requester 0 operands.
REQ-006 OP0  input  2  requester 0 opcode.
REQ-007 REQ1, IN1_1, IN2_1, OP1  input  1/WIDTH/WIDTH/2  requester 1 equivalents.
REQ-008 GNT0, GNT1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-009 VALID  output  1  one-cycle pulse: OUT holds a new result.
REQ-010 OUT  output  WIDTH  registered result.
REQ-011 OWNER  output  1  index of requester that owns the current/last result.
REQ-012 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, EXEC, DONE; registered; one operation in flight at most.
REQ-014 IDLE: no REQ -> stay IDLE; any REQ -> select winner, latch winner IN1/IN2/OP into internal regs, set OWNER, go EXEC.
REQ-015 Winner: only one REQ -> that requester; both REQ -> requester indicated by priority pointer PTR.
REQ-016 GNTx asserted for exactly the EXEC cycle of requester x's operation; GNT0 and GNT1 never high together.
REQ-017 EXEC: OUT <= f(latched IN1, latched IN2, OP); VALID <= 1; go DONE.
REQ-018 f: OP=00 bitwise AND; 01 bitwise OR; 10 bitwise XOR; 11 bitwise NAND; all WIDTH bits, no carry, no truncation.
REQ-019 DONE: VALID high this cycle only; PTR <= ~OWNER; go IDLE.
REQ-020 Latency: REQ sampled high in IDLE at edge N -> GNT high cycle N..N+1 -> VALID high cycle N+1..N+2; throughput one op per 3 cycles.
REQ-021 OUT and OWNER hold last values after VALID drops until next EXEC.
REQ-022 REQ changes or operand changes while BUSY are ignored; latched operands used.
REQ-023 Requester still asserting REQ when FSM returns to IDLE is served; with both continuously requesting, grants strictly alternate.
REQ-024 Single requester continuously requesting, other idle: served every 3 cycles regardless of PTR.
REQ-025 BUSY = (state != IDLE), combinational from state register.

Reset
REQ-026 RST_N low: immediately state=IDLE, OUT=0, VALID=0, GNT0=GNT1=0, OWNER=0, PTR=0, latched operands=0.
REQ-027 Reset mid-operation (EXEC or DONE) aborts; no VALID produced for aborted operation.
REQ-028 After RST_N deasserts, first rising edge with REQ high starts a new operation normally.

Verification
REQ-029 Only REQ0, IN1_0=32'h0000A5A5, IN2_0=32'h00005A5A, OP0=00 -> GNT0 one cycle, then VALID with OUT=32'h00000000, OWNER=0.
REQ-030 Only REQ1, IN1_1=IN2_1=32'h00005A5A, OP1=00 -> VALID, OUT=32'h00005A5A, OWNER=1; repeat OP1=01/10/11 -> 32'h00005A5A / 32'h00000000 / 32'hFFFFA5A5.
REQ-031 Out of reset, REQ0 and REQ1 high same edge, held for 4 ops -> grant order 0,1,0,1; each VALID 3 cycles apart; OUT matches owner operands.
REQ-032 Operands of granted requester changed during EXEC (IN1_0 to 32'hFFFFFFFF) -> OUT reflects values captured in IDLE, not new ones.
REQ-033 RST_N pulsed low during EXEC -> outputs zero at once, no VALID for aborted op; subsequent REQ0 completes with correct OUT.
REQ-034 Checker throughout: GNT0&GNT1 never 1; VALID never two consecutive cycles; BUSY low only in IDLE.
